// File: rtl/fwd_pkg.sv
// Shared constants and the producer-priority encoding for the forwarding/hazard unit.
package fwd_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int RAW  = $clog2(NREG);
  localparam int NSRC = 2;

  // Encoded in forwarding priority order, youngest producer first.
  typedef enum logic [1:0] {
    PRD_EX   = 2'd0,
    PRD_MM   = 2'd1,
    PRD_WB   = 2'd2,
    PRD_NONE = 2'd3
  } prd_e;

endpackage

// File: rtl/fwd_scoreboard.sv
// Busy bits for destinations owned by the long-latency unit, plus per-channel lookup.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NREG = fwd_pkg::NREG,
  parameter int NSRC = fwd_pkg::NSRC,
  parameter int RAW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lu_issue,
  input  logic [RAW-1:0]      lu_rd,
  input  logic                lu_done,
  input  logic [RAW-1:0]      lu_done_rd,
  input  logic                lu_kill,
  input  logic [NSRC*RAW-1:0] src_idx,
  input  logic [RAW-1:0]      rd_idx,
  output logic [NSRC-1:0]     src_busy,
  output logic                rd_busy
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  // Clear is applied before set so a fresh issue to the same register survives its old completion.
  always_comb begin
    busy_next = busy_reg;
    if (lu_kill) begin
      busy_next = '0;
    end else begin
      if (lu_done) busy_next[lu_done_rd] = 1'b0;
      if (lu_issue && (lu_rd != '0)) busy_next[lu_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_lookup
    assign src_busy[gi] = busy_reg[src_idx[gi*RAW +: RAW]];
  end

  assign rd_busy = busy_reg[rd_idx];

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use and long-op scoreboard hazard detection for the ID stage.
// Optional stall performance counters are built when FWD_PERF_EN is defined.
module fwd_hazard_unit #(
  parameter int XLEN = fwd_pkg::XLEN,
  parameter int NREG = fwd_pkg::NREG,
  parameter int NSRC = fwd_pkg::NSRC,
  parameter int RAW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*RAW-1:0]  id_rs,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic [RAW-1:0]       id_rd,
  input  logic                 id_rd_wen,
  input  logic                 ex_wen,
  input  logic [RAW-1:0]       ex_rd,
  input  logic                 ex_is_load,
  input  logic [XLEN-1:0]      ex_data,
  input  logic                 mm_wen,
  input  logic [RAW-1:0]       mm_rd,
  input  logic [XLEN-1:0]      mm_data,
  input  logic                 wb_wen,
  input  logic [RAW-1:0]       wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 lu_issue,
  input  logic [RAW-1:0]       lu_rd,
  input  logic                 lu_done,
  input  logic [RAW-1:0]       lu_done_rd,
  input  logic                 lu_kill,
  output logic [NSRC-1:0]      fw_en,
  output logic [NSRC*XLEN-1:0] fw_data,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic [31:0]          perf_lu_stall,
  output logic [31:0]          perf_sb_stall
);

  import fwd_pkg::*;

  logic [NSRC-1:0] src_busy;
  logic            rd_busy;
  logic [NSRC-1:0] lu_ch;
  logic [NSRC-1:0] sb_ch;
  logic            lu_haz;
  logic            sb_haz;

  fwd_scoreboard #(
    .NREG (NREG),
    .NSRC (NSRC),
    .RAW  (RAW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lu_issue   (lu_issue),
    .lu_rd      (lu_rd),
    .lu_done    (lu_done),
    .lu_done_rd (lu_done_rd),
    .lu_kill    (lu_kill),
    .src_idx    (id_rs),
    .rd_idx     (id_rd),
    .src_busy   (src_busy),
    .rd_busy    (rd_busy)
  );

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_ch
    logic [RAW-1:0]  rs;
    prd_e            sel;
    logic [XLEN-1:0] data;

    assign rs = id_rs[gi*RAW +: RAW];

    // A load in EX has no data yet, so it is skipped and left to the load-use stall.
    always_comb begin
      sel = PRD_NONE;
      if (rs != '0) begin
        if (ex_wen && !ex_is_load && (ex_rd == rs)) sel = PRD_EX;
        else if (mm_wen && (mm_rd == rs))           sel = PRD_MM;
        else if (wb_wen && (wb_rd == rs))           sel = PRD_WB;
      end
    end

    always_comb begin
      data = '0;
      case (sel)
        PRD_EX:  data = ex_data;
        PRD_MM:  data = mm_data;
        PRD_WB:  data = wb_data;
        default: data = '0;
      endcase
    end

    assign fw_en[gi]                 = (sel != PRD_NONE);
    assign fw_data[gi*XLEN +: XLEN]  = data;

    assign lu_ch[gi] = id_rs_used[gi] && (rs == ex_rd);
    // The completing result reaches ID through the WB bypass in the same cycle.
    assign sb_ch[gi] = id_rs_used[gi] && src_busy[gi] && !(lu_done && (lu_done_rd == rs));
  end

  assign lu_haz = id_valid && ex_wen && ex_is_load && (ex_rd != '0) && (|lu_ch);
  assign sb_haz = id_valid && ((|sb_ch) || (id_rd_wen && (id_rd != '0) && rd_busy));

  assign stall_id  = lu_haz || sb_haz;
  assign bubble_ex = stall_id;

`ifdef FWD_PERF_EN
  logic [31:0] perf_lu_reg;
  logic [31:0] perf_sb_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_reg <= '0;
      perf_sb_reg <= '0;
    end else begin
      if (lu_haz && (perf_lu_reg != 32'hFFFF_FFFF)) perf_lu_reg <= perf_lu_reg + 32'd1;
      if (sb_haz && (perf_sb_reg != 32'hFFFF_FFFF)) perf_sb_reg <= perf_sb_reg + 32'd1;
    end
  end

  assign perf_lu_stall = perf_lu_reg;
  assign perf_sb_stall = perf_sb_reg;
`else
  assign perf_lu_stall = '0;
  assign perf_sb_stall = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_fwd_hazard_unit;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NSRC = 2;
  localparam int RAW  = 5;
`ifdef FWD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 id_valid;
  logic [NSRC*RAW-1:0]  id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [RAW-1:0]       id_rd;
  logic                 id_rd_wen;
  logic                 ex_wen;
  logic [RAW-1:0]       ex_rd;
  logic                 ex_is_load;
  logic [XLEN-1:0]      ex_data;
  logic                 mm_wen;
  logic [RAW-1:0]       mm_rd;
  logic [XLEN-1:0]      mm_data;
  logic                 wb_wen;
  logic [RAW-1:0]       wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 lu_issue;
  logic [RAW-1:0]       lu_rd;
  logic                 lu_done;
  logic [RAW-1:0]       lu_done_rd;
  logic                 lu_kill;
  logic [NSRC-1:0]      fw_en;
  logic [NSRC*XLEN-1:0] fw_data;
  logic                 stall_id;
  logic                 bubble_ex;
  logic [31:0]          perf_lu_stall;
  logic [31:0]          perf_sb_stall;

  fwd_hazard_unit #(.XLEN(XLEN), .NREG(NREG), .NSRC(NSRC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_data(ex_data), .mm_wen(mm_wen), .mm_rd(mm_rd), .mm_data(mm_data), .wb_wen(wb_wen),
    .wb_rd(wb_rd), .wb_data(wb_data), .lu_issue(lu_issue), .lu_rd(lu_rd), .lu_done(lu_done),
    .lu_done_rd(lu_done_rd), .lu_kill(lu_kill), .fw_en(fw_en), .fw_data(fw_data),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .perf_lu_stall(perf_lu_stall),
    .perf_sb_stall(perf_sb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  en;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        st;
    bit          cp;
    logic [31:0] pl;
    logic [31:0] ps;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string nm, input string fld, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s %s got=%h want=%h", nm, fld, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      $display("txn %-12s fw_en=%b d0=%h d1=%h stall=%b perf=%0d/%0d",
               e.nm, fw_en, fw_data[63:0], fw_data[127:64], stall_id, perf_lu_stall, perf_sb_stall);
      cmp(e.nm, "fw_en", {62'd0, fw_en}, {62'd0, e.en});
      cmp(e.nm, "fw_data0", fw_data[63:0], e.d0);
      cmp(e.nm, "fw_data1", fw_data[127:64], e.d1);
      cmp(e.nm, "stall_id", {63'd0, stall_id}, {63'd0, e.st});
      cmp(e.nm, "bubble_ex", {63'd0, bubble_ex}, {63'd0, e.st});
      if (e.cp) begin
        cmp(e.nm, "perf_lu", {32'd0, perf_lu_stall}, {32'd0, e.pl});
        cmp(e.nm, "perf_sb", {32'd0, perf_sb_stall}, {32'd0, e.ps});
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_rd_wen = 0;
    ex_wen = 0; ex_rd = '0; ex_is_load = 0; ex_data = '0;
    mm_wen = 0; mm_rd = '0; mm_data = '0;
    wb_wen = 0; wb_rd = '0; wb_data = '0;
    lu_issue = 0; lu_rd = '0; lu_done = 0; lu_done_rd = '0; lu_kill = 0;
  endtask

  task automatic rd_src(input logic [RAW-1:0] rs0, input logic [RAW-1:0] rs1, input logic [1:0] used);
    id_valid = 1; id_rs = {rs1, rs0}; id_rs_used = used;
  endtask

  // Queue the expectation for the inputs currently applied, then advance one cycle.
  task automatic step(input string nm, input logic [1:0] en, input logic [63:0] d0, input logic [63:0] d1,
                      input logic st, input bit cp = 0, input logic [31:0] pl = 0, input logic [31:0] ps = 0);
    exp_t e;
    e.nm = nm; e.en = en; e.d0 = d0; e.d1 = d1; e.st = st; e.cp = cp; e.pl = pl; e.ps = ps;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    do_reset();

    step("reset", 2'b00, 64'h0, 64'h0, 1'b0, 1'b1, 32'd0, 32'd0);

    // EX beats MM on both channels
    ex_wen = 1; ex_rd = 5; ex_data = 64'h11; mm_wen = 1; mm_rd = 5; mm_data = 64'h22;
    rd_src(5, 5, 2'b11);
    step("ex_over_mm", 2'b11, 64'h11, 64'h11, 1'b0);

    // MM on ch0, WB on ch1, independent indices
    idle(); mm_wen = 1; mm_rd = 6; mm_data = 64'h22; wb_wen = 1; wb_rd = 8; wb_data = 64'h33;
    rd_src(6, 8, 2'b11);
    step("mm_wb_split", 2'b11, 64'h22, 64'h33, 1'b0);

    // MM beats WB for the same register
    idle(); mm_wen = 1; mm_rd = 4; mm_data = 64'hAA; wb_wen = 1; wb_rd = 4; wb_data = 64'hBB;
    rd_src(4, 0, 2'b01);
    step("mm_over_wb", 2'b01, 64'hAA, 64'h0, 1'b0);

    // Load-use: stall one cycle, then forward from MM
    idle(); ex_wen = 1; ex_is_load = 1; ex_rd = 7; ex_data = 64'hBAD;
    rd_src(1, 7, 2'b10);
    step("ld_use", 2'b00, 64'h0, 64'h0, 1'b1);
    idle(); mm_wen = 1; mm_rd = 7; mm_data = 64'hDEAD;
    rd_src(1, 7, 2'b10);
    step("ld_fwd_mm", 2'b10, 64'h0, 64'hDEAD, 1'b0);

    // Load to a register the channel does not actually read
    idle(); ex_wen = 1; ex_is_load = 1; ex_rd = 7;
    rd_src(1, 7, 2'b01);
    step("ld_unused", 2'b00, 64'h0, 64'h0, 1'b0);
    id_valid = 0; id_rs_used = 2'b10;
    step("ld_id_inval", 2'b00, 64'h0, 64'h0, 1'b0);

    // Long op to x9: dependent read stalls until completion bypass
    idle(); lu_issue = 1; lu_rd = 9;
    step("lu_issue9", 2'b00, 64'h0, 64'h0, 1'b0);
    idle(); rd_src(9, 0, 2'b01);
    for (int i = 0; i < 20; i++) step($sformatf("sb_wait%0d", i), 2'b00, 64'h0, 64'h0, 1'b1);
    lu_done = 1; lu_done_rd = 9; wb_wen = 1; wb_rd = 9; wb_data = 64'h5;
    step("lu_done9", 2'b01, 64'h5, 64'h0, 1'b0);
    idle(); rd_src(9, 0, 2'b01);
    step("x9_free", 2'b00, 64'h0, 64'h0, 1'b0);

    // WAW on the destination
    idle(); lu_issue = 1; lu_rd = 4;
    step("lu_issue4", 2'b00, 64'h0, 64'h0, 1'b0);
    idle(); id_valid = 1; id_rd = 4; id_rd_wen = 1;
    step("waw4", 2'b00, 64'h0, 64'h0, 1'b1);
    id_rd_wen = 0;
    step("rd_no_wen", 2'b00, 64'h0, 64'h0, 1'b0);
    idle(); lu_done = 1; lu_done_rd = 4;
    step("lu_done4", 2'b00, 64'h0, 64'h0, 1'b0);

    // Same-cycle issue and done on x3: set wins
    idle(); lu_issue = 1; lu_rd = 3; lu_done = 1; lu_done_rd = 3;
    step("iss_done3", 2'b00, 64'h0, 64'h0, 1'b0);
    idle(); rd_src(3, 0, 2'b01); lu_done = 1; lu_done_rd = 4;
    step("x3_busy", 2'b00, 64'h0, 64'h0, 1'b1);
    lu_done = 0; lu_kill = 1;
    step("kill_cycle", 2'b00, 64'h0, 64'h0, 1'b1);
    lu_kill = 0;
    step("x3_killed", 2'b00, 64'h0, 64'h0, 1'b0);

    // Kill beats a same-cycle issue
    idle(); lu_kill = 1; lu_issue = 1; lu_rd = 10;
    step("kill_iss10", 2'b00, 64'h0, 64'h0, 1'b0);
    idle(); rd_src(10, 0, 2'b01);
    step("x10_free", 2'b00, 64'h0, 64'h0, 1'b0);

    // Register 0 never forwards, stalls or becomes busy
    idle(); ex_wen = 1; ex_rd = 0; ex_data = 64'hFF; mm_wen = 1; wb_wen = 1;
    mm_data = 64'h1; wb_data = 64'h2; rd_src(0, 0, 2'b11);
    step("x0_fwd", 2'b00, 64'h0, 64'h0, 1'b0);
    ex_is_load = 1;
    step("x0_load", 2'b00, 64'h0, 64'h0, 1'b0);
    idle(); lu_issue = 1; lu_rd = 0;
    step("lu_issue0", 2'b00, 64'h0, 64'h0, 1'b0);
    idle(); rd_src(0, 0, 2'b11); id_rd_wen = 1;
    step("x0_notbusy", 2'b00, 64'h0, 64'h0, 1'b0);

    // Stall counters: 3 load-use cycles, 5 scoreboard cycles (one cycle counts both)
    do_reset();
    lu_issue = 1; lu_rd = 12;
    step("perf_iss12", 2'b00, 64'h0, 64'h0, 1'b0, 1'b1, 32'd0, 32'd0);
    idle(); ex_wen = 1; ex_is_load = 1; ex_rd = 7; rd_src(7, 0, 2'b01);
    step("perf_lu_a", 2'b00, 64'h0, 64'h0, 1'b1);
    step("perf_lu_b", 2'b00, 64'h0, 64'h0, 1'b1);
    rd_src(7, 12, 2'b11);
    step("perf_both", 2'b00, 64'h0, 64'h0, 1'b1);
    idle(); rd_src(12, 0, 2'b01);
    for (int i = 0; i < 4; i++) step($sformatf("perf_sb%0d", i), 2'b00, 64'h0, 64'h0, 1'b1);
    idle();
    step("perf_count", 2'b00, 64'h0, 64'h0, 1'b0, 1'b1, PERF ? 32'd3 : 32'd0, PERF ? 32'd5 : 32'd0);
    rd_src(12, 0, 2'b01);
    step("perf_sb_x", 2'b00, 64'h0, 64'h0, 1'b1);
    step("perf_sb_y", 2'b00, 64'h0, 64'h0, 1'b1);

    // Asynchronous reset mid-count clears counters and busy immediately
    rst_n = 0;
    step("async_rst", 2'b00, 64'h0, 64'h0, 1'b0, 1'b1, 32'd0, 32'd0);
    rst_n = 1;
    step("post_rst", 2'b00, 64'h0, 64'h0, 1'b0, 1'b1, 32'd0, 32'd0);

    idle();
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL monitor_drain pending=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the in-order pipeline (IF/ID/EX/MM/WB).
- Forwards operands to ID for NSRC source channels from three producers: EX, MM and WB.
- Detects load-use hazards and stalls ID / bubbles EX.
- Keeps a registered scoreboard of destinations owned by the multi-cycle long-latency unit (MUL/DIV), so dependent or WAW instructions stall until writeback.

Parameters:
- XLEN, 64, datapath width.
- NREG, 32, architectural register count; RAW = $clog2(NREG).
- NSRC, 2, number of source-operand channels checked per ID instruction.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs  in  NSRC*RAW  source indices; channel k is at [k*RAW +: RAW].
- id_rs_used  in  NSRC  channel k actually reads its source.
- id_rd  in  RAW  ID destination index.
- id_rd_wen  in  1  ID instruction writes id_rd.
- ex_wen  in  1  EX instruction writes back (already qualified by valid).
- ex_rd  in  RAW  EX destination index.
- ex_is_load  in  1  EX instruction is a load; data is not yet available.
- ex_data  in  XLEN  EX ALU result.
- mm_wen  in  1  MM writes back.
- mm_rd  in  RAW  MM destination index.
- mm_data  in  XLEN  MM writeback data (load data included).
- wb_wen  in  1  WB writes back.
- wb_rd  in  RAW  WB destination index.
- wb_data  in  XLEN  WB data.
- lu_issue  in  1  long unit accepts an op this cycle.
- lu_rd  in  RAW  destination of the issued op.
- lu_done  in  1  long unit result is presented on the WB port this cycle.
- lu_done_rd  in  RAW  destination of the completing op.
- lu_kill  in  1  pipeline flush also aborts all in-flight long ops.
- fw_en  out  NSRC  channel k takes forwarded data.
- fw_data  out  NSRC*XLEN  forwarded data per channel; 0 when not forwarding.
- stall_id  out  1  hold IF/ID.
- bubble_ex  out  1  insert a NOP into EX next cycle.
- perf_lu_stall  out  32  load-use stall cycles (FWD_PERF_EN only).
- perf_sb_stall  out  32  scoreboard stall cycles (FWD_PERF_EN only).

Behaviour:
- Register index 0 never matches any producer, never forwards, never sets busy.
- Forwarding per channel k, combinational, priority youngest first: EX (only if !ex_is_load), then MM, then WB.
  - A producer matches when its wen=1 and its rd==id_rs[k]!=0.
  - fw_en[k]=1 iff any producer matches; fw_data[k] = data of the highest-priority match, else 0.
  - Every channel is evaluated with its own index; no cross-channel terms.
- Load-use hazard: lu_haz = id_valid & ex_wen & ex_is_load & (ex_rd!=0) & any k (id_rs_used[k] & id_rs[k]==ex_rd).
- Scoreboard busy[NREG-1:0]:
  - Registered; resets to all 0 asynchronously.
  - lu_issue & lu_rd!=0 sets busy[lu_rd].
  - lu_done clears busy[lu_done_rd].
  - Same register set and cleared in one cycle: the set wins (a new issue supersedes the completion).
  - lu_kill clears all bits, taking priority over lu_issue in the same cycle.
- Scoreboard hazard: sb_haz = id_valid & ( any k (id_rs_used[k] & busy[id_rs[k]] & !(lu_done & lu_done_rd==id_rs[k])) | (id_rd_wen & id_rd!=0 & busy[id_rd]) ).
  - A completing result is bypassed through the WB forwarding path in the same cycle, so it does not stall.
- Outputs: stall_id = lu_haz | sb_haz; bubble_ex = stall_id.
- Latency: forwarding and hazard outputs are combinational from the inputs plus the registered busy; scoreboard updates are visible the cycle after the edge.
- Load-use stalls exactly 1 cycle: the load moves to MM and then forwards from MM.
- Reset mid-operation: busy is cleared and every in-flight long op is forgotten; the pipeline is required to be reset together with this unit.
- Combinational outputs have no reset value; they evaluate to 0 whenever all inputs are 0.

Optional Feature:
- FWD_PERF_EN defined: two 32-bit counters, reset to 0.
  - Each counts clk cycles with lu_haz=1 or sb_haz=1 respectively.
  - Both may increment in the same cycle.
  - Counters saturate at 0xFFFF_FFFF and do not wrap.
- FWD_PERF_EN undefined: the perf ports remain and are tied to 0; no counter flops are built.

Decomposition:
- Package fwd_pkg: XLEN, NREG, RAW and a producer-priority enum (PRD_EX, PRD_MM, PRD_WB, PRD_NONE).
- One sub-module, fwd_scoreboard: the busy array with its set/clear/kill logic and the per-index lookup.

Test Plan:
- EX addi x5 result 0x11 and MM x5 result 0x22, ID reads rs1=x5, rs2=x5 -> fw_en=2'b11, both channels 0x11, stall_id=0.
- EX load to x7, ID rs2=x7 used -> stall_id=1 for 1 cycle; next cycle MM mm_data=0xDEAD forwards on channel 1.
- lu_issue rd=x9, ID rs1=x9 for 20 cycles -> stall_id=1 throughout; on the lu_done cycle with wb_data=0x5 -> stall_id=0, fw_data ch0=0x5.
- lu_issue rd=x3 and lu_done rd=x3 in the same cycle -> busy[3]=1 after the edge; lu_kill then asserted -> busy all 0 and stall drops.
- Index-0 producers (ex_rd=0, wen=1) with ID rs1=0 -> fw_en=0, no stall; lu_issue rd=0 -> busy unchanged.
- With FWD_PERF_EN, force 3 load-use cycles plus 5 scoreboard cycles -> perf_lu_stall=3, perf_sb_stall=5; assert rst_n=0 mid-count -> both counters 0.
